config_shift_loader: RTL and testbench

- Upstream stage of every baked connection block's configuration chain.
- Accepts configuration words over a valid/ready stream and serializes them LSB-first onto the chain's shift input, asserting cen for each shifted bit.
- After exactly CHAIN_LEN bits it pulses the chain's set input and reports completion.
- One instance drives one daisy-chained tile column; its outputs connect to the shift_in, cen and set_in of the first block in the chain.

---
 rtl/config_shift_loader.sv | 104 ++++++++++
 tb/tb_config_shift_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/config_shift_loader.sv
// Feeds one configuration chain: takes words over valid/ready, shifts them out LSB-first
// with cen, then pulses set once exactly CHAIN_LEN bits have gone out.
module config_shift_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 20,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   output logic              word_ready,
   output logic              cen,
   output logic              shift_out,
   output logic              set_out,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bits_left,
   output logic [2:0]        state_dbg
);

   // Handshake: a word transfers on a rising edge where word_valid and word_ready are both 1;
   // word_ready is registered and only high in LOAD, so the source may hold valid at any time.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SHIFT = 3'd2,
      S_SET   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   state_t            state, state_n;
   logic [WORD_W-1:0] sr_q, sr_n;
   logic [CNT_W-1:0]  wcnt_q, wcnt_n;
   logic [CNT_W-1:0]  bits_n;

   assign state_dbg = state;

   always_comb begin
      state_n = state;
      sr_n    = sr_q;
      wcnt_n  = wcnt_q;
      bits_n  = bits_left;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = S_LOAD;
               bits_n  = CHAIN_LEN_C;
            end
         end
         S_LOAD: begin
            if (word_valid && word_ready) begin
               sr_n    = word_data;
               // A short final word only shifts the bits the chain still needs.
               wcnt_n  = (32'(bits_left) <= WORD_W) ? bits_left : CNT_W'(WORD_W);
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_n   = sr_q >> 1;
            wcnt_n = wcnt_q - ONE;
            bits_n = bits_left - ONE;
            if (bits_left == ONE)
               state_n = S_SET;
            else if (wcnt_q == ONE)
               state_n = S_LOAD;
         end
         S_SET:   state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         sr_q       <= '0;
         wcnt_q     <= '0;
         bits_left  <= '0;
         word_ready <= 1'b0;
         cen        <= 1'b0;
         shift_out  <= 1'b0;
         set_out    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         sr_q       <= sr_n;
         wcnt_q     <= wcnt_n;
         bits_left  <= bits_n;
         word_ready <= (state_n == S_LOAD);
         cen        <= (state_n == S_SHIFT);
         shift_out  <= (state_n == S_SHIFT) && sr_n[0];
         set_out    <= (state_n == S_SET);
         busy       <= (state_n == S_LOAD) || (state_n == S_SHIFT) || (state_n == S_SET);
         done       <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_config_shift_loader.sv
// Bench for config_shift_loader: a 20-bit chain and a 16-bit chain driven by random words,
// with the expected serial stream built from the word list.
module tb_config_shift_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start      [2];
   logic       word_valid [2];
   logic [7:0] word_data  [2];
   logic       word_ready [2];
   logic       cen        [2];
   logic       shift_out  [2];
   logic       set_out    [2];
   logic       busy       [2];
   logic       done       [2];
   logic [4:0] bits_left  [2];
   logic [2:0] state_dbg  [2];

   config_shift_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut20 (
      .clk(clk), .rst(rst), .start(start[0]), .word_valid(word_valid[0]),
      .word_data(word_data[0]), .word_ready(word_ready[0]), .cen(cen[0]),
      .shift_out(shift_out[0]), .set_out(set_out[0]), .busy(busy[0]), .done(done[0]),
      .bits_left(bits_left[0]), .state_dbg(state_dbg[0])
   );

   config_shift_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut16 (
      .clk(clk), .rst(rst), .start(start[1]), .word_valid(word_valid[1]),
      .word_data(word_data[1]), .word_ready(word_ready[1]), .cen(cen[1]),
      .shift_out(shift_out[1]), .set_out(set_out[1]), .busy(busy[1]), .done(done[1]),
      .bits_left(bits_left[1]), .state_dbg(state_dbg[1])
   );

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] src_words [$];
   logic [0:0] exp_q [$];
   logic [0:0] got_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] outs(input int s);
      return 32'({word_ready[s], cen[s], shift_out[s], set_out[s], busy[s], done[s], bits_left[s]});
   endfunction

   // One complete load on DUT sel; stall = LOAD cycles withheld after word 1,
   // noise = junk valid and a start pulse while shifting, rst_at >= 0 aborts via reset.
   task automatic run_load(input int sel, input int clen, input int stall, input bit noise,
                           input int rst_at, input string tag);
      int nwords, idx, ncen, nset, t, t_set, stall_cnt;
      bit finished, aborted, stalling;
      logic [31:0] gv, ev;
      nwords = (clen + 7) / 8;
      exp_q.delete();
      got_q.delete();
      for (int w = 0; w < nwords; w++)
         for (int b = 0; b < 8; b++)
            if (exp_q.size() < clen) exp_q.push_back(src_words[w][b]);

      start[sel] = 1'b1;
      tick();
      start[sel] = 1'b0;
      check({tag, " load entry"}, 32'({busy[sel], done[sel], word_ready[sel], cen[sel], bits_left[sel]}),
            32'({1'b1, 1'b0, 1'b1, 1'b0, 5'(clen)}));

      idx = 0; ncen = 0; nset = 0; t = 1; t_set = 0; stall_cnt = 0;
      finished = 1'b0; aborted = 1'b0;
      while (!finished && !aborted && t < 300) begin
         if (cen[sel]) begin
            got_q.push_back(shift_out[sel]);
            ncen++;
         end
         if (set_out[sel]) begin
            nset++;
            t_set = t;
            finished = 1'b1;
         end
         if (rst_at >= 0 && cen[sel] && int'(bits_left[sel]) == rst_at) begin
            rst = 1'b0;
            #1;
            check({tag, " reset outputs"}, outs(sel), 32'd0);
            word_valid[sel] = 1'b0;
            repeat (3) begin
               tick();
               if (set_out[sel]) nset++;
            end
            check({tag, " no set on abort"}, 32'(nset), 32'd0);
            check({tag, " held in reset"}, outs(sel), 32'd0);
            rst = 1'b1;
            aborted = 1'b1;
         end else if (!finished) begin
            start[sel] = (noise && cen[sel] && ncen == 3);
            stalling = (idx == 1 && stall_cnt < stall && word_ready[sel]);
            if (stalling) begin
               check({tag, " stall cen"}, 32'(cen[sel]), 32'd0);
               check({tag, " stall bits_left"}, 32'(bits_left[sel]), 32'(clen - 8));
               stall_cnt++;
               word_valid[sel] = 1'b0;
            end else if (noise && cen[sel]) begin
               word_valid[sel] = 1'b1;
               word_data[sel]  = 8'($urandom);
            end else if (idx < nwords) begin
               word_valid[sel] = 1'b1;
               word_data[sel]  = src_words[idx];
               if (word_ready[sel]) idx++;
            end else begin
               word_valid[sel] = 1'b0;
            end
            tick();
            t++;
         end
      end
      word_valid[sel] = 1'b0;
      start[sel] = 1'b0;

      if (!aborted) begin
         if (!finished) check({tag, " set timeout"}, 32'd0, 32'd1);
         check({tag, " cen count"}, 32'(ncen), 32'(clen));
         check({tag, " words taken"}, 32'(idx), 32'(nwords));
         check({tag, " set cycle"}, 32'(t_set), 32'(1 + nwords + clen + stall));
         gv = '0;
         ev = '0;
         for (int i = 0; i < got_q.size() && i < 32; i++) gv[i] = got_q[i];
         for (int i = 0; i < exp_q.size(); i++) ev[i] = exp_q[i];
         check({tag, " bit stream"}, gv, ev);
         tick();
         check({tag, " done state"}, 32'({set_out[sel], cen[sel], busy[sel], done[sel], word_ready[sel]}),
               32'(5'b00010));
      end
   endtask

   task automatic rand_words(input int n);
      src_words.delete();
      for (int i = 0; i < n; i++) src_words.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         start[s] = 1'b1;
         word_valid[s] = 1'b1;
         word_data[s] = 8'hA5;
      end
      repeat (3) tick();
      check("reset dut20", outs(0), 32'd0);
      check("reset dut16", outs(1), 32'd0);
      for (int s = 0; s < 2; s++) begin
         start[s] = 1'b0;
         word_valid[s] = 1'b0;
      end
      rst = 1'b1;
      tick();
      check("idle after release", outs(0), 32'd0);

      src_words = '{8'hA5, 8'h3C, 8'hFF};
      run_load(0, 20, 0, 1'b0, -1, "nominal");
      run_load(0, 20, 5, 1'b0, -1, "stalled");
      run_load(0, 20, 0, 1'b1, -1, "ignored inputs");

      rand_words(3);
      run_load(0, 20, 0, 1'b0, 7, "abort");
      tick();
      check("idle after abort", outs(0), 32'd0);
      rand_words(3);
      run_load(0, 20, 0, 1'b0, -1, "after abort");

      for (int k = 0; k < 4; k++) begin
         rand_words(3);
         run_load(0, 20, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, "random20");
      end

      rand_words(2);
      run_load(1, 16, 0, 1'b0, -1, "chain16");
      rand_words(2);
      run_load(1, 16, 0, 1'b0, -1, "chain16 back2back");
      rand_words(2);
      run_load(1, 16, 2, 1'b1, -1, "chain16 random");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
